// File: rtl/fnd_scan_controller_if.sv
// Display-side bus of the 7-segment scan controller: packed digit data,
// decimal-point mask and enable in; active-low segment and digit enables out.
interface fnd_scan_controller_if;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        en;
  logic [7:0]  seg;
  logic [3:0]  com;

  modport master (output value, dp_mask, en, input seg, com);
  modport slave  (input value, dp_mask, en, output seg, com);
endinterface

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with registered outputs.
// Define FND_LEAD_ZERO_BLANK_EN to blank leading zero digits 3..1.
module fnd_scan_controller #(
  parameter int SCAN_DIV  = 100_000,
  parameter int BLANK_CYC = 16
) (
  input logic                   clk,
  input logic                   reset_p,
  fnd_scan_controller_if.slave  bus
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);

  logic [CW-1:0] cnt;
  logic [1:0]    dig;
  logic [15:0]   snap_val;
  logic [3:0]    snap_dp;

  logic [3:0]    nibble;
  logic [6:0]    pattern;
  logic          lz_blank;
  logic [3:0]    com_next;
  logic [7:0]    seg_next;

  // Snapshot is taken only at the start of a frame so a frame never mixes two values.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      cnt      <= '0;
      dig      <= 2'd0;
      snap_val <= 16'h0000;
      snap_dp  <= 4'h0;
    end else begin
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        dig <= dig + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (dig == 2'd0 && cnt == '0) begin
        snap_val <= bus.value;
        snap_dp  <= bus.dp_mask;
      end
    end
  end

  assign nibble = snap_val[{dig, 2'b00} +: 4];

  always_comb begin
    pattern = 7'h7F;
    case (nibble)
      4'h0: pattern = 7'b100_0000;
      4'h1: pattern = 7'b111_1001;
      4'h2: pattern = 7'b010_0100;
      4'h3: pattern = 7'b011_0000;
      4'h4: pattern = 7'b001_1001;
      4'h5: pattern = 7'b001_0010;
      4'h6: pattern = 7'b000_0010;
      4'h7: pattern = 7'b101_1000;
      4'h8: pattern = 7'b000_0000;
      4'h9: pattern = 7'b001_0000;
      4'hA: pattern = 7'b000_1000;
      4'hB: pattern = 7'b000_0011;
      4'hC: pattern = 7'b100_0110;
      4'hD: pattern = 7'b010_0001;
      4'hE: pattern = 7'b000_0110;
      4'hF: pattern = 7'b000_1110;
      default: pattern = 7'h7F;
    endcase
  end

`ifdef FND_LEAD_ZERO_BLANK_EN
  // A digit is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    lz_blank = 1'b0;
    case (dig)
      2'd3:    lz_blank = (snap_val[15:12] == 4'h0);
      2'd2:    lz_blank = (snap_val[15:8]  == 8'h00);
      2'd1:    lz_blank = (snap_val[15:4]  == 12'h000);
      default: lz_blank = 1'b0;
    endcase
  end
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    com_next = 4'b1111;
    seg_next = 8'hFF;
    if (bus.en && cnt >= BLANK_LIM) begin
      com_next = ~(4'b0001 << dig);
      seg_next = {~snap_dp[dig], (lz_blank ? 7'h7F : pattern)};
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      bus.com <= 4'b1111;
      bus.seg <= 8'hFF;
    end else begin
      bus.com <= com_next;
      bus.seg <= seg_next;
    end
  end

endmodule
